// File: rtl/btb_ctrl.sv
// -----------------------------------------------------------------------------
// btb_ctrl
//
// Arbitration and write sequencing for a single-ported branch target buffer
// array. Fetch lookups and resolved-branch updates from EX compete for the
// one array port. Updates are parked in a 2-entry FIFO and drained whenever
// fetch is not using the port. A starvation counter forces a drain when the
// queue stays full behind lookups for too long. A flush request walks every
// set and clears it, one set per cycle.
//
// Ports
//   CLK, nRST      clock (rising edge), asynchronous active-low reset
//   lookup_req     fetch wants the array port this cycle
//   lookup_gnt     array port is given to the lookup this cycle
//   upd_valid      EX presents a resolved branch (pc/target/taken)
//   upd_ready      update queue can take the branch this cycle
//   upd_pc         PC of the resolved branch
//   upd_target     resolved branch target
//   upd_taken      branch was taken (not-taken invalidates the entry)
//   flush_req      invalidate every BTB set
//   flush_busy     flush walk in progress
//   arr_we         array write strobe
//   arr_idx        array set index to write
//   arr_wtag       tag to write
//   arr_wtarget    target to write
//   arr_wvalid     valid bit to write
//   dbg_state      FSM state (0 = IDLE, 1 = FLUSH)
//   dbg_count      number of queued updates
//
// Handshake: an update transfers on a rising CLK edge where
// upd_valid && upd_ready. upd_ready does not depend on upd_valid, and it is
// deliberately not raised when the queue is full even if the head is being
// written out in the same cycle.
// -----------------------------------------------------------------------------
module btb_ctrl #(
  parameter int ENTRIES    = 16,
  parameter int STARVE_MAX = 4,
  localparam int IW        = $clog2(ENTRIES),
  localparam int TW        = 30 - IW
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          lookup_req,
  output logic          lookup_gnt,
  input  logic          upd_valid,
  input  logic [31:0]   upd_pc,
  input  logic [31:0]   upd_target,
  input  logic          upd_taken,
  output logic          upd_ready,
  input  logic          flush_req,
  output logic          flush_busy,
  output logic          arr_we,
  output logic [IW-1:0] arr_idx,
  output logic [TW-1:0] arr_wtag,
  output logic [31:0]   arr_wtarget,
  output logic          arr_wvalid,
  output logic          dbg_state,
  output logic [1:0]    dbg_count
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [IW-1:0] LAST_IDX   = IW'(ENTRIES - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
    logic [31:0]   target;
    logic          taken;
  } upd_t;

  state_t        state;
  upd_t          fifo [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic [SW-1:0] starve;
  logic [IW-1:0] fidx;

  upd_t new_ent;
  upd_t head;
  logic push;
  logic do_pop;
  logic flush_go;

  assign new_ent.idx    = upd_pc[IW+1:2];
  assign new_ent.tag    = upd_pc[31:IW+2];
  assign new_ent.target = upd_target;
  assign new_ent.taken  = upd_taken;

  assign head       = fifo[rd_ptr];
  assign upd_ready  = (state == IDLE) && (count != 2'd2);
  assign push       = upd_valid && upd_ready;
  assign flush_busy = (state == FLUSH);
  assign dbg_state  = state;
  assign dbg_count  = count;

  // Port arbitration. Priority in IDLE: flush, lookup (unless starving a
  // full queue), queued write. nRST gates the flush so that while reset is
  // held the port simply follows lookup_req.
  always_comb begin
    lookup_gnt  = 1'b0;
    arr_we      = 1'b0;
    arr_idx     = '0;
    arr_wtag    = '0;
    arr_wtarget = '0;
    arr_wvalid  = 1'b0;
    flush_go    = 1'b0;
    do_pop      = 1'b0;
    if (state == FLUSH) begin
      arr_we  = 1'b1;
      arr_idx = fidx;
    end else if (flush_req && nRST) begin
      flush_go = 1'b1;
    end else if (lookup_req && (starve < STARVE_LIM)) begin
      lookup_gnt = 1'b1;
    end else if (count != 2'd0) begin
      do_pop      = 1'b1;
      arr_we      = 1'b1;
      arr_idx     = head.idx;
      arr_wtag    = head.tag;
      arr_wtarget = head.target;
      arr_wvalid  = head.taken;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      count   <= 2'd0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      starve  <= '0;
      fidx    <= '0;
      fifo[0] <= '0;
      fifo[1] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (flush_go) begin
            // Pending updates are dropped: the walk would erase them anyway.
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            starve <= '0;
            fidx   <= '0;
            state  <= FLUSH;
          end else begin
            if (push) begin
              fifo[wr_ptr] <= new_ent;
              wr_ptr       <= ~wr_ptr;
            end
            if (do_pop) begin
              rd_ptr <= ~rd_ptr;
            end
            if (push && !do_pop) begin
              count <= count + 2'd1;
            end else if (!push && do_pop) begin
              count <= count - 2'd1;
            end
            // Starvation only counts while the queue is full and losing the
            // port to fetch; any drain resets it.
            if (do_pop) begin
              starve <= '0;
            end else if ((count == 2'd2) && lookup_gnt && (starve < STARVE_LIM)) begin
              starve <= starve + SW'(1);
            end
          end
        end
        FLUSH: begin
          // fidx wraps back to 0 after the last set.
          fidx <= fidx + IW'(1);
          if (fidx == LAST_IDX) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_btb_ctrl.sv
module tb_btb_ctrl;

  localparam int ENTRIES    = 16;
  localparam int STARVE_MAX = 4;
  localparam int IW         = $clog2(ENTRIES);
  localparam int TW         = 30 - IW;
  localparam int W          = IW + TW + 33;

  logic          CLK;
  logic          nRST;
  logic          lookup_req;
  logic          lookup_gnt;
  logic          upd_valid;
  logic [31:0]   upd_pc;
  logic [31:0]   upd_target;
  logic          upd_taken;
  logic          upd_ready;
  logic          flush_req;
  logic          flush_busy;
  logic          arr_we;
  logic [IW-1:0] arr_idx;
  logic [TW-1:0] arr_wtag;
  logic [31:0]   arr_wtarget;
  logic          arr_wvalid;
  logic          dbg_state;
  logic [1:0]    dbg_count;

  int n_checks = 0;
  int n_errors = 0;

  btb_ctrl #(.ENTRIES(ENTRIES), .STARVE_MAX(STARVE_MAX)) dut (
    .CLK(CLK), .nRST(nRST),
    .lookup_req(lookup_req), .lookup_gnt(lookup_gnt),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken), .upd_ready(upd_ready),
    .flush_req(flush_req), .flush_busy(flush_busy),
    .arr_we(arr_we), .arr_idx(arr_idx), .arr_wtag(arr_wtag),
    .arr_wtarget(arr_wtarget), .arr_wvalid(arr_wvalid),
    .dbg_state(dbg_state), .dbg_count(dbg_count)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Queue of pending updates, each packed as {idx, tag, target, taken}.
  logic [W-1:0] exp_q[$];
  bit m_flush  = 0;
  int m_fidx   = 0;
  int m_starve = 0;

  function automatic logic [W-1:0] mk_ent(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    int unsigned idx;
    int unsigned tag;
    logic [IW-1:0] i_bits;
    logic [TW-1:0] t_bits;
    idx = (pc / 4) % ENTRIES;
    tag = pc / (4 * ENTRIES);
    i_bits = idx[IW-1:0];
    t_bits = tag[TW-1:0];
    return {i_bits, t_bits, tgt, tk};
  endfunction

  // Model state advances on each clock edge; reset clears it at once.
  initial begin
    forever begin
      @(posedge CLK or negedge nRST);
      if (!nRST) begin
        exp_q.delete();
        m_flush  = 0;
        m_fidx   = 0;
        m_starve = 0;
      end else if (m_flush) begin
        m_fidx++;
        if (m_fidx == ENTRIES) begin
          m_flush = 0;
          m_fidx  = 0;
        end
      end else if (flush_req) begin
        exp_q.delete();
        m_starve = 0;
        m_fidx   = 0;
        m_flush  = 1;
      end else begin
        bit can_take;
        bit granted;
        bit wrote;
        int depth;
        depth    = exp_q.size();
        can_take = upd_valid && (depth < 2);
        granted  = lookup_req && (m_starve < STARVE_MAX);
        wrote    = !granted && (depth > 0);
        if (wrote) begin
          void'(exp_q.pop_front());
          m_starve = 0;
        end else if (depth == 2 && granted && m_starve < STARVE_MAX) begin
          m_starve++;
        end
        if (can_take) exp_q.push_back(mk_ent(upd_pc, upd_target, upd_taken));
      end
    end
  end

  // Scoreboard: every falling edge the outputs must match the model.
  initial begin
    forever begin
      logic          e_ready, e_gnt, e_busy, e_we, e_val;
      logic [IW-1:0] e_idx;
      logic [TW-1:0] e_tag;
      logic [31:0]   e_tgt;
      logic [W-1:0]  hd;
      @(negedge CLK);
      e_ready = 0; e_gnt = 0; e_busy = 0; e_we = 0; e_val = 0;
      e_idx = '0; e_tag = '0; e_tgt = '0;
      if (!nRST) begin
        e_ready = 1;
        e_gnt   = lookup_req;
      end else if (m_flush) begin
        e_busy = 1;
        e_we   = 1;
        e_idx  = IW'(m_fidx);
      end else begin
        e_ready = (exp_q.size() < 2);
        if (flush_req) begin
          e_gnt = 0;
        end else if (lookup_req && m_starve < STARVE_MAX) begin
          e_gnt = 1;
        end else if (exp_q.size() > 0) begin
          hd = exp_q[0];
          e_we = 1;
          {e_idx, e_tag, e_tgt, e_val} = hd;
        end
      end
      check("upd_ready",   64'(upd_ready),   64'(e_ready));
      check("lookup_gnt",  64'(lookup_gnt),  64'(e_gnt));
      check("flush_busy",  64'(flush_busy),  64'(e_busy));
      check("dbg_state",   64'(dbg_state),   64'(e_busy));
      check("arr_we",      64'(arr_we),      64'(e_we));
      check("arr_idx",     64'(arr_idx),     64'(e_idx));
      check("arr_wtag",    64'(arr_wtag),    64'(e_tag));
      check("arr_wtarget", 64'(arr_wtarget), 64'(e_tgt));
      check("arr_wvalid",  64'(arr_wvalid),  64'(e_val));
      check("dbg_count",   64'(dbg_count),   64'(nRST ? exp_q.size() : 0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_upd(input logic v, input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    upd_valid  = v;
    upd_pc     = pc;
    upd_target = tgt;
    upd_taken  = tk;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    nRST       = 1'b0;
    lookup_req = 1'b1;
    flush_req  = 1'b1;
    drive_upd(1'b0, 32'h0, 32'h0, 1'b0);

    // Held in reset: port follows lookup_req even with flush_req high.
    @(negedge CLK);
    check("rst_flush_busy", 64'(flush_busy), 64'd0);
    check("rst_arr_we",     64'(arr_we),     64'd0);
    check("rst_upd_ready",  64'(upd_ready),  64'd1);
    check("rst_lookup_gnt", 64'(lookup_gnt), 64'd1);
    step();
    step();
    lookup_req = 1'b0;
    flush_req  = 1'b0;
    nRST       = 1'b1;

    // Taken branch at pc 0x44: set 1, tag 1.
    step();
    drive_upd(1'b1, 32'h0000_0044, 32'h0000_0100, 1'b1);
    step();
    drive_upd(1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge CLK);
    check("t1_we",     64'(arr_we),      64'd1);
    check("t1_idx",    64'(arr_idx),     64'd1);
    check("t1_tag",    64'(arr_wtag),    64'h1);
    check("t1_target", 64'(arr_wtarget), 64'h100);
    check("t1_valid",  64'(arr_wvalid),  64'd1);

    // Not-taken branch at the same pc invalidates set 1.
    step();
    drive_upd(1'b1, 32'h0000_0044, 32'h0000_0100, 1'b0);
    step();
    drive_upd(1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge CLK);
    check("t2_we",    64'(arr_we),     64'd1);
    check("t2_idx",   64'(arr_idx),    64'd1);
    check("t2_valid", 64'(arr_wvalid), 64'd0);

    // Full queue behind constant lookups: four granted cycles, then forced write.
    step();
    lookup_req = 1'b1;
    drive_upd(1'b1, 32'h1000_0008, 32'h0000_00A0, 1'b1);
    step();
    drive_upd(1'b1, 32'h2000_000C, 32'h0000_00B0, 1'b1);
    step();
    drive_upd(1'b0, 32'h0, 32'h0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      check("t3_full_ready", 64'(upd_ready),  64'd0);
      check("t3_full_gnt",   64'(lookup_gnt), 64'd1);
      check("t3_full_we",    64'(arr_we),     64'd0);
      step();
    end
    @(negedge CLK);
    check("t3_forced_gnt",    64'(lookup_gnt),  64'd0);
    check("t3_forced_we",     64'(arr_we),      64'd1);
    check("t3_forced_idx",    64'(arr_idx),     64'd2);
    check("t3_forced_tag",    64'(arr_wtag),    64'h40_0000);
    check("t3_forced_target", 64'(arr_wtarget), 64'hA0);
    check("t3_forced_ready",  64'(upd_ready),   64'd0);
    step();
    @(negedge CLK);
    check("t3_after_ready", 64'(upd_ready),  64'd1);
    check("t3_after_gnt",   64'(lookup_gnt), 64'd1);
    lookup_req = 1'b0;
    step();
    step();

    // One entry queued, flush discards it and walks sets 0..15.
    lookup_req = 1'b1;
    drive_upd(1'b1, 32'h0000_0024, 32'h0000_0C00, 1'b1);
    step();
    drive_upd(1'b0, 32'h0, 32'h0, 1'b0);
    flush_req = 1'b1;
    @(negedge CLK);
    check("t4_req_we",  64'(arr_we),     64'd0);
    check("t4_req_gnt", 64'(lookup_gnt), 64'd0);
    step();
    flush_req = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (i == 5) flush_req = 1'b1;
      if (i == 7) flush_req = 1'b0;
      @(negedge CLK);
      check("t4_walk_busy",  64'(flush_busy), 64'd1);
      check("t4_walk_we",    64'(arr_we),     64'd1);
      check("t4_walk_idx",   64'(arr_idx),    64'(i));
      check("t4_walk_valid", 64'(arr_wvalid), 64'd0);
      check("t4_walk_gnt",   64'(lookup_gnt), 64'd0);
      check("t4_walk_ready", 64'(upd_ready),  64'd0);
      step();
    end
    lookup_req = 1'b0;
    @(negedge CLK);
    check("t4_done_busy",  64'(flush_busy), 64'd0);
    check("t4_done_count", 64'(dbg_count),  64'd0);
    check("t4_done_we",    64'(arr_we),     64'd0);

    // Reset in the middle of a walk.
    step();
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    repeat (7) step();
    @(negedge CLK);
    check("t5_mid_idx", 64'(arr_idx), 64'd7);
    #2;
    nRST = 1'b0;
    #1;
    check("t5_rst_busy", 64'(flush_busy), 64'd0);
    check("t5_rst_we",   64'(arr_we),     64'd0);
    step();
    step();
    nRST = 1'b1;
    @(negedge CLK);
    check("t5_post_busy", 64'(flush_busy), 64'd0);
    check("t5_post_we",   64'(arr_we),     64'd0);

    // Push and pop together with one entry queued.
    step();
    lookup_req = 1'b1;
    drive_upd(1'b1, 32'h0000_0030, 32'h0000_00D0, 1'b1);
    step();
    lookup_req = 1'b0;
    drive_upd(1'b1, 32'h0000_0054, 32'h0000_00E0, 1'b1);
    @(negedge CLK);
    check("t6_pop_idx", 64'(arr_idx), 64'hC);
    step();
    drive_upd(1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge CLK);
    check("t6_count",  64'(dbg_count),   64'd1);
    check("t6_idx",    64'(arr_idx),     64'd5);
    check("t6_target", 64'(arr_wtarget), 64'hE0);
    step();

    // Mixed traffic, checked by the scoreboard alone.
    for (int c = 0; c < 400; c++) begin
      lookup_req = ($urandom_range(0, 3) != 0);
      flush_req  = ($urandom_range(0, 60) == 0);
      drive_upd(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)));
      step();
    end
    lookup_req = 1'b0;
    flush_req  = 1'b0;
    drive_upd(1'b0, 32'h0, 32'h0, 1'b0);
    repeat (24) step();

    @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
